gate_response_checker: RTL and testbench

- Self-checking stimulus/response engine: the driving and checking side of the basic two-input gate set (AND, OR, NOT).
- Each run sweeps (a,b) through 00, 01, 10, 11 on its outputs.
- After a programmable settle delay it samples the three gate outputs and compares them to the expected truth table.
- Reports per-vector failures, a saturating error count and a pass/done verdict, so gate models can be checked in simulation without waveform inspection.

---
 rtl/gate_response_checker_if.sv | 22 ++
 rtl/gate_response_checker.sv | 81 ++++++++
 tb/tb_gate_response_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: stimulus, observed gate outputs and verdict of a gate checker
interface gate_response_checker_if #(parameter int ERR_W = 3);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             y_and_in;
  logic             y_or_in;
  logic             y_not_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;
  modport master (
    input  start, y_and_in, y_or_in, y_not_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );
  modport slave (
    output start, y_and_in, y_or_in, y_not_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps (a,b) through 00..11 and checks AND/OR/NOT responses
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W = 3
) (
  input logic clk,
  input logic rst,
  gate_response_checker_if.master bus
);
  localparam int SC = SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES;
  localparam int CW = $clog2(SC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t           state, state_n;
  logic [1:0]       vec_idx, vec_idx_n;
  logic [1:0]       ab, ab_n;
  logic [CW-1:0]    settle_cnt, settle_cnt_n;
  logic [ERR_W-1:0] err_count, err_n;
  logic [3:0]       fail_vec, fail_n;
  logic             go, miss;
  assign go = bus.start && (state == IDLE || state == DONE);
  // case inequality so X/Z on an observed output is a failure
  assign miss = (bus.y_and_in !== (ab[1] & ab[0])) ||
                (bus.y_or_in  !== (ab[1] | ab[0])) ||
                (bus.y_not_in !== ~ab[1]);
  always_comb begin
    state_n      = state;
    vec_idx_n    = vec_idx;
    ab_n         = ab;
    settle_cnt_n = settle_cnt;
    err_n        = err_count;
    fail_n       = fail_vec;
    if (go) begin
      state_n      = SETTLE;
      vec_idx_n    = 2'd0;
      ab_n         = 2'd0;
      settle_cnt_n = CW'(SC);
      err_n        = '0;
      fail_n       = 4'd0;
    end else if (state == SETTLE) begin
      settle_cnt_n = settle_cnt - 1'b1;
      state_n      = settle_cnt == CW'(1) ? CHECK : SETTLE;
    end else if (state == CHECK) begin
      if (miss) begin
        fail_n[vec_idx] = 1'b1;
        err_n           = &err_count ? err_count : err_count + 1'b1;
      end
      if (vec_idx == 2'd3) begin
        state_n = DONE;
      end else begin
        state_n      = SETTLE;
        vec_idx_n    = vec_idx + 2'd1;
        ab_n         = vec_idx + 2'd1;
        settle_cnt_n = CW'(SC);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec_idx    <= 2'd0;
      ab         <= 2'd0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_vec   <= 4'd0;
    end else begin
      state      <= state_n;
      vec_idx    <= vec_idx_n;
      ab         <= ab_n;
      settle_cnt <= settle_cnt_n;
      err_count  <= err_n;
      fail_vec   <= fail_n;
    end
  end
  assign bus.a_out     = ab[1];
  assign bus.b_out     = ab[0];
  assign bus.busy      = state == SETTLE || state == CHECK;
  assign bus.done      = state == DONE;
  assign bus.pass      = state == DONE && err_count == '0;
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed sweeps against good and faulty gate models
module tb_gate_response_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;
  gate_response_checker_if #(.ERR_W(3)) g1 ();
  gate_response_checker_if #(.ERR_W(1)) g2 ();
  gate_response_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) dut1 (.clk(clk), .rst(rst), .bus(g1));
  gate_response_checker #(.SETTLE_CYCLES(3), .ERR_W(1)) dut2 (.clk(clk), .rst(rst), .bus(g2));
  always #5 clk = ~clk;
  // mode 0 good gates, 1 OR stuck at 0, 2 NOT fed from b
  always_comb begin
    g1.y_and_in = g1.a_out & g1.b_out;
    g1.y_or_in  = mode == 1 ? 1'b0 : g1.a_out | g1.b_out;
    g1.y_not_in = mode == 2 ? ~g1.b_out : ~g1.a_out;
  end
  assign g2.y_and_in = ~(g2.a_out & g2.b_out);
  assign g2.y_or_in  = ~(g2.a_out | g2.b_out);
  assign g2.y_not_in = g2.a_out;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start1();
    g1.start = 1'b1;
    tick();
    g1.start = 1'b0;
  endtask
  task automatic sweep1();
    start1();
    for (int k = 0; k < 8; k++) begin
      chk("busy1", 32'(g1.busy), 32'd1);
      chk("ab1", 32'({g1.a_out, g1.b_out}), 32'(k / 2));
      tick();
    end
    chk("done1", 32'(g1.done), 32'd1);
  endtask
  initial begin
    g1.start = 1'b0;
    g2.start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_done", 32'(g1.done), 32'd0);
    chk("rst_busy", 32'(g1.busy), 32'd0);
    chk("rst_pass", 32'(g1.pass), 32'd0);
    chk("rst_ab", 32'({g1.a_out, g1.b_out}), 32'd0);
    chk("rst_err", 32'(g1.err_count), 32'd0);
    chk("rst_fv", 32'(g1.fail_vec), 32'd0);
    chk("rst2_busy", 32'(g2.busy), 32'd0);
    sweep1();
    chk("good_pass", 32'(g1.pass), 32'd1);
    chk("good_err", 32'(g1.err_count), 32'd0);
    chk("good_fv", 32'(g1.fail_vec), 32'h0);
    chk("good_ab", 32'({g1.a_out, g1.b_out}), 32'd3);
    tick();
    chk("done_hold", 32'(g1.done), 32'd1);
    mode = 1;
    sweep1();
    chk("or0_fv", 32'(g1.fail_vec), 32'he);
    chk("or0_err", 32'(g1.err_count), 32'd3);
    chk("or0_pass", 32'(g1.pass), 32'd0);
    mode = 2;
    sweep1();
    chk("notb_fv", 32'(g1.fail_vec), 32'h6);
    chk("notb_err", 32'(g1.err_count), 32'd2);
    chk("notb_pass", 32'(g1.pass), 32'd0);
    mode = 1;
    start1();
    tick();
    tick();
    chk("restart_ab", 32'({g1.a_out, g1.b_out}), 32'd1);
    start1();
    for (int k = 3; k < 8; k++) begin
      chk("restart_busy", 32'(g1.busy), 32'd1);
      chk("restart_seq", 32'({g1.a_out, g1.b_out}), 32'(k / 2));
      tick();
    end
    chk("restart_done", 32'(g1.done), 32'd1);
    chk("restart_fv", 32'(g1.fail_vec), 32'he);
    chk("restart_err", 32'(g1.err_count), 32'd3);
    start1();
    chk("again_done", 32'(g1.done), 32'd0);
    chk("again_err", 32'(g1.err_count), 32'd0);
    chk("again_fv", 32'(g1.fail_vec), 32'd0);
    chk("again_ab", 32'({g1.a_out, g1.b_out}), 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_fv", 32'(g1.fail_vec), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(g1.busy), 32'd0);
    chk("abort_done", 32'(g1.done), 32'd0);
    chk("abort_ab", 32'({g1.a_out, g1.b_out}), 32'd0);
    chk("abort_err", 32'(g1.err_count), 32'd0);
    chk("abort_fv", 32'(g1.fail_vec), 32'd0);
    tick();
    chk("abort_idle", 32'(g1.busy), 32'd0);
    mode = 0;
    sweep1();
    chk("fresh_pass", 32'(g1.pass), 32'd1);
    chk("fresh_fv", 32'(g1.fail_vec), 32'd0);
    g2.start = 1'b1;
    tick();
    g2.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("inv_busy", 32'(g2.busy), 32'd1);
      chk("inv_done_early", 32'(g2.done), 32'd0);
      chk("inv_ab", 32'({g2.a_out, g2.b_out}), 32'(k / 4));
      tick();
    end
    chk("inv_done", 32'(g2.done), 32'd1);
    chk("inv_busy_end", 32'(g2.busy), 32'd0);
    chk("inv_fv", 32'(g2.fail_vec), 32'hf);
    chk("inv_err_sat", 32'(g2.err_count), 32'd1);
    chk("inv_pass", 32'(g2.pass), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
